// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control/status bundle between front panel, control and phase_sequencer
//
// Signals:
//   exec        run/stop button level (asynchronous)
//   step        single-step button level (asynchronous)
//   halt        decoded halt instruction, only meaningful in P5
//   stall       freeze current phase
//   phase       current phase, 0 idle/halted, 1..5 = P1..P5
//   ir_e        instruction-register load strobe
//   pc_e        program-counter advance strobe
//   running     high in P1..P5
//   halted      high in HALT
//   instr_count retired-instruction counter
// Modports: master drives the control inputs, slave is the sequencer.
interface phase_sequencer_if;
    logic        exec;
    logic        step;
    logic        halt;
    logic        stall;
    logic [2:0]  phase;
    logic        ir_e;
    logic        pc_e;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        output exec, step, halt, stall,
        input  phase, ir_e, pc_e, running, halted, instr_count
    );

    modport slave (
        input  exec, step, halt, stall,
        output phase, ir_e, pc_e, running, halted, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - five-phase instruction sequencer with run/stop, halt and stall control
//
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-low reset
//   bus  phase_sequencer_if.slave: exec/step/halt/stall in,
//        phase/ir_e/pc_e/running/halted/instr_count out
// Build option: STEP_MODE_EN adds the single-step button path; without it
// the step input is accepted but ignored.
module phase_sequencer (
    input  logic             clk,
    input  logic             rst,
    phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4,
        P5   = 3'd5,
        HALT = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        stop_req;
    logic        stop_nxt;
    logic        exec_s1;
    logic        exec_s2;
    logic        exec_s3;
    logic        exec_pulse;
    logic        step_start;
    logic        step_end;
    logic        start_exec;
    logic        start_step;
    logic        to_rest;
    logic        retire;
    logic        in_run;
    logic [2:0]  phase_q;
    logic        running_q;
    logic        halted_q;
    logic [15:0] instr_count_q;

    // Two-flop synchronizer, then exec_s3 holds the previous synchronized
    // level so the pulse is one cycle wide and appears after the 2nd edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_s1 <= 1'b0;
            exec_s2 <= 1'b0;
            exec_s3 <= 1'b0;
        end else begin
            exec_s1 <= bus.exec;
            exec_s2 <= exec_s1;
            exec_s3 <= exec_s2;
        end
    end

    assign exec_pulse = exec_s2 & ~exec_s3;

`ifdef STEP_MODE_EN
    logic step_s1;
    logic step_s2;
    logic step_s3;
    logic step_req;

    // step_req marks an instruction started by the step button, so it
    // returns to IDLE at the end of P5 instead of looping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_s1  <= 1'b0;
            step_s2  <= 1'b0;
            step_s3  <= 1'b0;
            step_req <= 1'b0;
        end else begin
            step_s1 <= bus.step;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
            if (start_exec || to_rest) begin
                step_req <= 1'b0;
            end else if (start_step) begin
                step_req <= 1'b1;
            end
        end
    end

    assign step_start = step_s2 & ~step_s3;
    assign step_end   = step_req;
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign step_start  = 1'b0;
    assign step_end    = 1'b0;
`endif

    assign in_run = (state != IDLE) && (state != HALT);

    always_comb begin
        state_nxt  = state;
        stop_nxt   = stop_req;
        start_exec = 1'b0;
        start_step = 1'b0;
        to_rest    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (exec_pulse) begin
                    state_nxt  = P1;
                    start_exec = 1'b1;
                end else if (step_start) begin
                    state_nxt  = P1;
                    start_step = 1'b1;
                end
            end
            P1: if (!bus.stall) state_nxt = P2;
            P2: if (!bus.stall) state_nxt = P3;
            P3: if (!bus.stall) state_nxt = P4;
            P4: if (!bus.stall) state_nxt = P5;
            P5: begin
                if (!bus.stall) begin
                    retire = 1'b1;
                    // halt wins over a pending stop request
                    if (bus.halt) begin
                        state_nxt = HALT;
                        to_rest   = 1'b1;
                    end else if (stop_req || exec_pulse || step_end) begin
                        state_nxt = IDLE;
                        to_rest   = 1'b1;
                    end else begin
                        state_nxt = P1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                to_rest   = 1'b1;
            end
        endcase

        if (start_exec || start_step || to_rest) begin
            stop_nxt = 1'b0;
        end else if (exec_pulse && in_run) begin
            stop_nxt = 1'b1;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            stop_req      <= 1'b0;
            phase_q       <= 3'd0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            state         <= state_nxt;
            stop_req      <= stop_nxt;
            phase_q       <= (state_nxt == HALT) ? 3'd0 : 3'(state_nxt);
            running_q     <= (state_nxt != IDLE) && (state_nxt != HALT);
            halted_q      <= (state_nxt == HALT);
            instr_count_q <= instr_count_q + {15'd0, retire};
        end
    end

    // Strobes depend only on the state register and stall, never on the
    // asynchronous buttons.
    assign bus.ir_e        = (state == P1) && !bus.stall;
    assign bus.pc_e        = (state == P5) && !bus.stall;
    assign bus.phase       = phase_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - table-driven self-checking bench for phase_sequencer
module tb_phase_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;

    phase_sequencer_if bus ();

    phase_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exec;
        logic        halt;
        logic        stall;
        logic        step;
        logic [2:0]  phase;
        logic        ir_e;
        logic        pc_e;
        logic        running;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic e, input logic h, input logic s, input logic st,
                                input logic [2:0] ph, input logic ir, input logic pc,
                                input logic run, input logic hl, input logic [15:0] cnt);
        vec_t v;
        v.exec    = e;
        v.halt    = h;
        v.stall   = s;
        v.step    = st;
        v.phase   = ph;
        v.ir_e    = ir;
        v.pc_e    = pc;
        v.running = run;
        v.halted  = hl;
        v.cnt     = cnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ph, input logic ir, input logic pc,
                           input logic run, input logic hl, input logic [15:0] cnt);
        chk({tag, ".phase"},   {13'd0, bus.phase},   {13'd0, ph});
        chk({tag, ".ir_e"},    {15'd0, bus.ir_e},    {15'd0, ir});
        chk({tag, ".pc_e"},    {15'd0, bus.pc_e},    {15'd0, pc});
        chk({tag, ".running"}, {15'd0, bus.running}, {15'd0, run});
        chk({tag, ".halted"},  {15'd0, bus.halted},  {15'd0, hl});
        chk({tag, ".count"},   bus.instr_count,      cnt);
    endtask

    // Inputs are driven on the falling edge and outputs sampled 1 ns later,
    // so each row sees the state after the previous rising edge.
    task automatic apply_tbl(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.exec  = tbl[i].exec;
            bus.halt  = tbl[i].halt;
            bus.stall = tbl[i].stall;
            bus.step  = tbl[i].step;
            #1;
            chk_all($sformatf("%s%0d", tag, i), tbl[i].phase, tbl[i].ir_e, tbl[i].pc_e,
                    tbl[i].running, tbl[i].halted, tbl[i].cnt);
        end
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        n_checks  = 0;
        n_errs    = 0;
        rst       = 1'b0;
        bus.exec  = 1'b0;
        bus.halt  = 1'b0;
        bus.stall = 1'b0;
        bus.step  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // run from exec rise, then stop requested during P2 of instruction 3
        add(1,0,0,0, 0,0,0,0,0, 0);
        add(1,0,0,0, 0,0,0,0,0, 0);
        add(1,0,0,0, 0,0,0,0,0, 0);
        add(1,0,0,0, 1,1,0,1,0, 0);
        add(1,0,0,0, 2,0,0,1,0, 0);
        add(1,0,0,0, 3,0,0,1,0, 0);
        add(1,0,0,0, 4,0,0,1,0, 0);
        add(1,0,0,0, 5,0,1,1,0, 0);
        add(1,0,0,0, 1,1,0,1,0, 1);
        add(0,0,0,0, 2,0,0,1,0, 1);
        add(0,0,0,0, 3,0,0,1,0, 1);
        add(0,0,0,0, 4,0,0,1,0, 1);
        add(0,0,0,0, 5,0,1,1,0, 1);
        add(0,0,0,0, 1,1,0,1,0, 2);
        add(1,0,0,0, 2,0,0,1,0, 2);
        add(1,0,0,0, 3,0,0,1,0, 2);
        add(1,0,0,0, 4,0,0,1,0, 2);
        add(1,0,0,0, 5,0,1,1,0, 2);
        add(0,0,0,0, 0,0,0,0,0, 3);
        add(0,1,1,0, 0,0,0,0,0, 3);
        add(0,0,0,0, 0,0,0,0,0, 3);
        // halt and exec pulse together in P5: halt wins
        add(1,0,0,0, 0,0,0,0,0, 3);
        add(1,0,0,0, 0,0,0,0,0, 3);
        add(1,0,0,0, 0,0,0,0,0, 3);
        add(0,0,0,0, 1,1,0,1,0, 3);
        add(0,0,0,0, 2,0,0,1,0, 3);
        add(1,1,0,0, 3,0,0,1,0, 3);
        add(1,0,0,0, 4,0,0,1,0, 3);
        add(1,1,0,0, 5,0,1,1,0, 3);
        add(1,0,0,0, 0,0,0,0,1, 4);
        add(0,0,0,0, 0,0,0,0,1, 4);
        add(0,0,0,0, 0,0,0,0,1, 4);
        add(1,0,0,0, 0,0,0,0,1, 4);
        add(1,0,0,0, 0,0,0,0,1, 4);
        add(1,0,0,0, 0,0,0,0,1, 4);
        add(0,0,0,0, 1,1,0,1,0, 4);
        add(0,0,0,0, 2,0,0,1,0, 4);
        add(0,0,0,0, 3,0,0,1,0, 4);
        add(0,0,0,0, 4,0,0,1,0, 4);
        add(0,0,0,0, 5,0,1,1,0, 4);
        // stall in P1 and for 4 cycles in P5, halt ignored while stalled
        add(0,0,1,0, 1,0,0,1,0, 5);
        add(0,0,0,0, 1,1,0,1,0, 5);
        add(0,0,0,0, 2,0,0,1,0, 5);
        add(0,0,0,0, 3,0,0,1,0, 5);
        add(0,0,0,0, 4,0,0,1,0, 5);
        add(0,0,1,0, 5,0,0,1,0, 5);
        add(0,1,1,0, 5,0,0,1,0, 5);
        add(0,0,1,0, 5,0,0,1,0, 5);
        add(0,0,1,0, 5,0,0,1,0, 5);
        add(0,0,0,0, 5,0,1,1,0, 5);
        add(0,0,0,0, 1,1,0,1,0, 6);
        apply_tbl("run");

        // asynchronous reset in the middle of P3
        k = 0;
        while (bus.phase !== 3'd3 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("reach_p3", {13'd0, bus.phase}, 16'd3);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        #1;
        chk_all("rst_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        bus.exec = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // exec already high at reset release: first change on 3rd edge
        add(1,0,0,0, 0,0,0,0,0, 0);
        add(1,0,0,0, 0,0,0,0,0, 0);
        add(1,0,0,0, 1,1,0,1,0, 0);
        apply_tbl("rst_exit");

        force dut.instr_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.instr_count_q;
        #1;
        chk("preload.phase", {13'd0, bus.phase}, 16'd2);
        chk("preload.count", bus.instr_count, 16'hFFFF);

        // counter wrap, then stop request seen in P3
        add(1,0,0,0, 3,0,0,1,0, 16'hFFFF);
        add(0,0,0,0, 4,0,0,1,0, 16'hFFFF);
        add(0,0,0,0, 5,0,1,1,0, 16'hFFFF);
        add(1,0,0,0, 1,1,0,1,0, 16'h0000);
        add(1,0,0,0, 2,0,0,1,0, 16'h0000);
        add(1,0,0,0, 3,0,0,1,0, 16'h0000);
        add(0,0,0,0, 4,0,0,1,0, 16'h0000);
        add(0,0,0,0, 5,0,1,1,0, 16'h0000);
        add(0,0,0,0, 0,0,0,0,0, 16'h0001);
        add(0,0,0,0, 0,0,0,0,0, 16'h0001);
        apply_tbl("wrap");

        // step button from IDLE
`ifdef STEP_MODE_EN
        add(0,0,0,1, 0,0,0,0,0, 1);
        add(0,0,0,1, 0,0,0,0,0, 1);
        add(0,0,0,1, 0,0,0,0,0, 1);
        add(0,0,0,1, 1,1,0,1,0, 1);
        add(0,0,0,1, 2,0,0,1,0, 1);
        add(0,0,0,1, 3,0,0,1,0, 1);
        add(0,0,0,1, 4,0,0,1,0, 1);
        add(0,0,0,1, 5,0,1,1,0, 1);
        add(0,0,0,1, 0,0,0,0,0, 2);
        add(0,0,0,1, 0,0,0,0,0, 2);
`else
        for (int i = 0; i < 10; i++) begin
            add(0,0,0,1, 0,0,0,0,0, 1);
        end
`endif
        apply_tbl("step");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port exec  input  1  run/stop push-button level, asynchronous to clk.
REQ-004 SHALL have port step  input  1  single-step button level, asynchronous; used only per REQ-030.
REQ-005 SHALL have port halt  input  1  decoded halt instruction from control, sampled in P5.
REQ-006 SHALL have port stall  input  1  freeze current phase (memory/datapath wait).
REQ-007 SHALL have port phase  output  3  current phase: 0 idle/halted, 1..5 = P1..P5.
REQ-008 SHALL have port ir_e  output  1  instruction-register load strobe.
REQ-009 SHALL have port pc_e  output  1  program-counter advance strobe.
REQ-010 SHALL have port running  output  1  1 while in P1..P5.
REQ-011 SHALL have port halted  output  1  1 while in HALT state.
REQ-012 SHALL have port instr_count  output  16  retired-instruction counter.

Function
REQ-013 SHALL implement states IDLE, P1, P2, P3, P4, P5, HALT; phase = 1..5 in P1..P5, 0 in IDLE and HALT.
REQ-014 SHALL pass exec and step each through a 2-flop synchronizer plus rising-edge detector, giving one-cycle exec_pulse / step_pulse.
REQ-015 SHALL make the first state change occur on the 3rd rising clk edge after exec rises (sync1, sync2, edge-detect), assuming setup met.
REQ-016 SHALL advance P1->P2->P3->P4->P5 one state per clk when stall=0; any state P1..P5 holds unchanged while stall=1.
REQ-017 SHALL, in IDLE or HALT on exec_pulse, go to P1 and clear the pending stop request; other inputs ignored there.
REQ-018 SHALL latch exec_pulse seen in P1..P5 into stop_req; stop_req persists until the next IDLE/HALT entry clears it.
REQ-019 SHALL, at P5 with stall=0: halt=1 -> HALT; else stop_req=1 (or exec_pulse this cycle) -> IDLE; else -> P1.
REQ-020 SHALL give halt priority over stop_req when both are present in P5.
REQ-021 SHALL drive ir_e=1 exactly when state=P1 and stall=0; pc_e=1 exactly when state=P5 and stall=0; both decoded from state register, no path from exec/step.
REQ-022 SHALL increment instr_count by 1 on every P5 exit (stall=0), wrapping 16'hFFFF -> 16'h0000; never cleared except by reset.
REQ-023 SHALL ignore halt outside P5 and ignore halt while stalled in P5.
REQ-024 SHALL assert running=1 in P1..P5 and halted=1 only in HALT.

Reset
REQ-025 SHALL, on rst=0, asynchronously force state=IDLE, stop_req=0, step_req=0, synchronizer/edge flops=0.
REQ-026 SHALL hold outputs at reset: phase=0, ir_e=0, pc_e=0, running=0, halted=0, instr_count=0.
REQ-027 SHALL abandon an instruction mid-phase on reset with no pc_e or count increment emitted.
REQ-028 SHALL leave reset synchronously: first state change no earlier than the 3rd rising edge after rst rises with exec already high (edge detector sees 0->1).

Configuration
REQ-029 SHALL compile single-step support only when macro STEP_MODE_EN is defined.
REQ-030 SHALL, with STEP_MODE_EN: step_pulse in IDLE/HALT -> P1 with step_req=1; P5 exit with step_req=1 -> IDLE (halt still -> HALT); step_req cleared on IDLE/HALT entry; step_pulse in P1..P5 ignored.
REQ-031 SHALL, without STEP_MODE_EN: step port present but unused, no step synchronizer logic, behaviour identical to REQ-013..024.

Verification
REQ-032 SHALL cover run: reset, exec 0->1, stall=0 -> phase 1,2,3,4,5,1 on edges 3..8; ir_e high at edges 3,8 windows; pc_e one cycle in each P5; instr_count=1 after first P5.
REQ-033 SHALL cover stop: exec pulsed during P2 of 3rd instruction -> completes P5, phase=0, running=0, instr_count=3.
REQ-034 SHALL cover halt priority: halt=1 and exec_pulse both in P5 -> HALT, halted=1, phase=0; next exec_pulse -> P1, halted=0.
REQ-035 SHALL cover stall: stall=1 for 4 cycles in P5 -> phase stays 5, pc_e=0, instr_count unchanged; stall=0 -> single pc_e, count +1.
REQ-036 SHALL cover wrap and reset: preload to 16'hFFFF via 65535 instructions -> next P5 gives 16'h0000; rst=0 asserted in P3 -> immediately phase=0, all outputs 0.
REQ-037 SHALL cover STEP_MODE_EN build: step pulse from IDLE -> exactly P1..P5 once, one pc_e, back to IDLE, instr_count +1.
